counter_readout_latch: RTL and testbench

- Per-counter read path of the 8254 timer; one instance per counter (C0, C1, C2).
- Receives the 6-bit programming field and the 2-bit readback command produced by the control word decoder for that counter.
- Captures counter-latch and status-latch snapshots and sequences the bytes returned to the CPU over the data bus.
- This is the read-side counterpart of control word decoding: it turns those commands into the byte stream the CPU reads.

---
 rtl/counter_readout_latch.sv | 127 ++++++++++++
 tb/tb_counter_readout_latch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_readout_latch.sv
// Per-counter read path of an 8254-style timer: counter/status latch capture and
// CPU byte sequencing onto the data bus.
module counter_readout_latch #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         program_bits,
  input  logic               program_strobe,
  input  logic [1:0]         readback,
  input  logic               readback_strobe,
  input  logic [COUNT_W-1:0] count_value,
  input  logic               out_pin,
  input  logic               null_count,
  input  logic               rd_strobe,
  output logic [7:0]         read_data,
  output logic               count_latched,
  output logic               status_latched,
  output logic [1:0]         rw_mode
);

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_WORD  = 2'b11;

  logic [1:0]         r_rw;
  logic [2:0]         r_mode;
  logic               r_bcd;
  logic               r_cnt_lat;
  logic               r_sts_lat;
  logic               r_bp;
  logic [COUNT_W-1:0] r_cnt_snap;
  logic [7:0]         r_sts_snap;

  logic               w_new_mode;
  logic               w_latch_cmd;
  logic               w_rb_cmd;
  logic               w_read;
  logic               w_cnt_lat_rd;
  logic               w_sts_lat_rd;
  logic               w_bp_rd;
  logic               w_cap_cnt;
  logic               w_cap_sts;
  logic [7:0]         w_sts_byte;
  logic [COUNT_W-1:0] w_cnt_src;

  function automatic logic [7:0] sel_byte(input logic [COUNT_W-1:0] src,
                                          input logic [1:0]         rw,
                                          input logic               bp);
    logic [7:0] b;
    case (rw)
      RW_LSB:  b = src[7:0];
      RW_MSB:  b = src[15:8];
      default: b = bp ? src[15:8] : src[7:0];
    endcase
    return b;
  endfunction

  assign w_sts_byte = {out_pin, null_count, r_rw, r_mode, r_bcd};
  assign w_cnt_src  = r_cnt_lat ? r_cnt_snap : count_value;

  // A new-mode write swallows a coincident read; latch commands see post-read state.
  always_comb begin
    w_new_mode   = program_strobe && (program_bits[5:4] != RW_LATCH);
    w_latch_cmd  = program_strobe && (program_bits[5:4] == RW_LATCH);
    w_rb_cmd     = readback_strobe && !program_strobe;
    w_read       = rd_strobe && !w_new_mode;
    w_cnt_lat_rd = r_cnt_lat;
    w_sts_lat_rd = r_sts_lat;
    w_bp_rd      = r_bp;
    if (w_read) begin
      if (r_sts_lat) begin
        w_sts_lat_rd = 1'b0;
      end else if (r_rw == RW_WORD) begin
        if (r_bp) begin
          w_bp_rd      = 1'b0;
          w_cnt_lat_rd = 1'b0;
        end else begin
          w_bp_rd      = 1'b1;
        end
      end else begin
        w_cnt_lat_rd = 1'b0;
      end
    end
    w_cap_cnt = !w_cnt_lat_rd && (w_latch_cmd || (w_rb_cmd && !readback[1]));
    w_cap_sts = !w_sts_lat_rd && w_rb_cmd && !readback[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw      <= RW_WORD;
      r_mode    <= 3'b000;
      r_bcd     <= 1'b0;
      r_cnt_lat <= 1'b0;
      r_sts_lat <= 1'b0;
      r_bp      <= 1'b0;
    end else if (w_new_mode) begin
      r_rw      <= program_bits[5:4];
      r_mode    <= program_bits[3:1];
      r_bcd     <= program_bits[0];
      r_cnt_lat <= 1'b0;
      r_sts_lat <= 1'b0;
      r_bp      <= 1'b0;
    end else begin
      r_cnt_lat <= w_cnt_lat_rd | w_cap_cnt;
      r_sts_lat <= w_sts_lat_rd | w_cap_sts;
      r_bp      <= w_bp_rd;
    end
  end

  // Snapshot data is only observed while its flag is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_cap_cnt) r_cnt_snap <= count_value;
    if (w_cap_sts) r_sts_snap <= w_sts_byte;
  end

  always_comb begin
    if (r_sts_lat) read_data = r_sts_snap;
    else           read_data = sel_byte(w_cnt_src, r_rw, r_bp);
  end

  assign count_latched  = r_cnt_lat;
  assign status_latched = r_sts_lat;
  assign rw_mode        = r_rw;

endmodule

// File: tb/tb_counter_readout_latch.sv
// Bench for counter_readout_latch: reference model checked every cycle plus
// hand-computed byte expectations for the directed sequences.
module tb_counter_readout_latch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  program_bits = '0;
  logic        program_strobe = 1'b0;
  logic [1:0]  readback = 2'b11;
  logic        readback_strobe = 1'b0;
  logic [15:0] count_value = '0;
  logic        out_pin = 1'b0;
  logic        null_count = 1'b0;
  logic        rd_strobe = 1'b0;
  logic [7:0]  read_data;
  logic        count_latched;
  logic        status_latched;
  logic [1:0]  rw_mode;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  counter_readout_latch #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .program_bits(program_bits),
    .program_strobe(program_strobe), .readback(readback),
    .readback_strobe(readback_strobe), .count_value(count_value),
    .out_pin(out_pin), .null_count(null_count), .rd_strobe(rd_strobe),
    .read_data(read_data), .count_latched(count_latched),
    .status_latched(status_latched), .rw_mode(rw_mode)
  );

  always #5 clk = ~clk;

  // Reference model: what the CPU should see, from the read-path rules.
  logic [1:0]  m_rw = 2'b11;
  logic [2:0]  m_mode = 3'b000;
  logic        m_bcd = 1'b0;
  logic        m_cl = 1'b0;
  logic        m_sl = 1'b0;
  logic        m_bp = 1'b0;
  logic [15:0] m_snap = '0;
  logic [7:0]  m_sts = '0;

  function automatic logic [7:0] m_byte();
    logic [15:0] src;
    if (m_sl) return m_sts;
    src = m_cl ? m_snap : count_value;
    if (m_rw == 2'b01) return src[7:0];
    if (m_rw == 2'b10) return src[15:8];
    return m_bp ? src[15:8] : src[7:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rw = 2'b11; m_mode = 3'b000; m_bcd = 1'b0;
      m_cl = 1'b0; m_sl = 1'b0; m_bp = 1'b0;
    end else if (program_strobe && program_bits[5:4] != 2'b00) begin
      m_rw = program_bits[5:4]; m_mode = program_bits[3:1]; m_bcd = program_bits[0];
      m_cl = 1'b0; m_sl = 1'b0; m_bp = 1'b0;
    end else begin
      if (rd_strobe) begin
        if (m_sl) m_sl = 1'b0;
        else if (m_rw != 2'b11) m_cl = 1'b0;
        else if (!m_bp) m_bp = 1'b1;
        else begin m_bp = 1'b0; m_cl = 1'b0; end
      end
      if (program_strobe) begin
        if (!m_cl) begin m_cl = 1'b1; m_snap = count_value; end
      end else if (readback_strobe) begin
        if (!readback[1] && !m_cl) begin m_cl = 1'b1; m_snap = count_value; end
        if (!readback[0] && !m_sl) begin
          m_sl = 1'b1; m_sts = {out_pin, null_count, m_rw, m_mode, m_bcd};
        end
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("mdl_read_data", {8'h00, read_data}, {8'h00, m_byte()});
      check("mdl_count_latched", {15'h0, count_latched}, {15'h0, m_cl});
      check("mdl_status_latched", {15'h0, status_latched}, {15'h0, m_sl});
      check("mdl_rw_mode", {14'h0, rw_mode}, {14'h0, m_rw});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    program_strobe = 1'b0;
    readback_strobe = 1'b0;
    rd_strobe = 1'b0;
  endtask

  task automatic expect_rd(input string nm, input logic [7:0] exp);
    #1;
    check(nm, {8'h00, read_data}, {8'h00, exp});
  endtask

  task automatic rd(input string nm, input logic [7:0] exp);
    expect_rd(nm, exp);
    rd_strobe = 1'b1;
    tick();
  endtask

  task automatic prog(input logic [5:0] p);
    program_bits = p;
    program_strobe = 1'b1;
    tick();
  endtask

  task automatic rb(input logic [1:0] r);
    readback = r;
    readback_strobe = 1'b1;
    tick();
  endtask

  initial begin
    #2 reset = 1'b1;
    count_value = 16'h1234;
    @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    check("reset_rw_mode", {14'h0, rw_mode}, 16'h0003);
    check("reset_flags", {14'h0, count_latched, status_latched}, 16'h0000);
    rd("t1_lsb", 8'h34);
    rd("t1_msb", 8'h12);
    expect_rd("t1_wrap", 8'h34);

    count_value = 16'hABCD;
    prog(6'b000000);
    count_value = 16'h0001;
    prog(6'b000000);
    rd("t2_lat_lsb", 8'hCD);
    rd("t2_lat_msb", 8'hAB);
    rd("t2_live_lsb", 8'h01);
    rd("t2_live_msb", 8'h00);

    prog(6'b010110);
    count_value = 16'h5A3C;
    rd("t3_lsb_only_a", 8'h3C);
    rd("t3_lsb_only_b", 8'h3C);
    rd("t3_lsb_only_c", 8'h3C);
    prog(6'b100000);
    rd("t3_msb_only_a", 8'h5A);
    rd("t3_msb_only_b", 8'h5A);

    prog(6'b110101);
    count_value = 16'h0102;
    out_pin = 1'b1;
    null_count = 1'b0;
    rb(2'b00);
    count_value = 16'h0304;
    rd("t4_status", 8'hB5);
    rd("t4_lat_lsb", 8'h02);
    rd("t4_lat_msb", 8'h01);
    rd("t4_live_lsb", 8'h04);
    rd("t4_live_msb", 8'h03);

    count_value = 16'h7788;
    prog(6'b000000);
    count_value = 16'h99AA;
    rd("t5_lat_lsb", 8'h88);
    program_bits = 6'b110000;
    program_strobe = 1'b1;
    rd_strobe = 1'b1;
    tick();
    expect_rd("t5_prog_wins", 8'hAA);
    check("t5_cnt_cleared", {15'h0, count_latched}, 16'h0000);
    rd("t5_live_lsb", 8'hAA);
    rd("t5_live_msb", 8'h99);

    out_pin = 1'b0;
    null_count = 1'b1;
    count_value = 16'h1122;
    rd("t6_live_lsb", 8'h22);
    rb(2'b10);
    check("t6_sts_only", {14'h0, count_latched, status_latched}, 16'h0001);
    expect_rd("t6_status", 8'h70);
    out_pin = 1'b1;
    readback = 2'b10;
    readback_strobe = 1'b1;
    rd_strobe = 1'b1;
    tick();
    expect_rd("t6_recapture", 8'hF0);
    prog(6'b000000);
    check("t6_both_held", {14'h0, count_latched, status_latched}, 16'h0003);
    #2 reset = 1'b1;
    #1;
    check("t6_async_flags", {14'h0, count_latched, status_latched}, 16'h0000);
    check("t6_async_rw", {14'h0, rw_mode}, 16'h0003);
    check("t6_async_data", {8'h00, read_data}, 16'h0022);
    @(posedge clk);
    #1 reset = 1'b0;
    rd("t6_post_lsb", 8'h22);
    rd("t6_post_msb", 8'h11);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
